// File: rtl/lighting_pkg.sv
// Shared types and default constants for the lighting output stage.
// Imported by light_fader and pwm_gen.
package lighting_pkg;

    localparam int unsigned LP_PWM_BITS = 8;
    localparam int unsigned LP_STEP_DIV = 1000;
    localparam int unsigned LP_STEP     = 1;

    typedef enum logic [1:0] {
        DARK      = 2'd0,
        FADE_UP   = 2'd1,
        BRIGHT    = 2'd2,
        FADE_DOWN = 2'd3
    } fade_state_t;

    // Upstream smart-lighting controller state; its light_on output feeds this stage.
    typedef enum logic [1:0] {
        CTL_IDLE     = 2'd0,
        CTL_OCCUPIED = 2'd1,
        CTL_HOLD     = 2'd2,
        CTL_TIMEOUT  = 2'd3
    } state_t;

endpackage

// File: rtl/light_fader_pwm_gen.sv
// Free-running PWM counter and compare; the output is registered, so it
// lags the level input by one clock.
module pwm_gen
    import lighting_pkg::*;
#(
    parameter int unsigned PWM_BITS = LP_PWM_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] level,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0] r_cnt;
    logic                r_pwm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_cnt <= r_cnt + PWM_BITS'(1);
            r_pwm <= (r_cnt < level);
        end
    end

    assign pwm_out = r_pwm;

endmodule

// File: rtl/light_fader.sv
// Lamp output stage: ramps brightness towards the light_on target in STEP
// increments every STEP_DIV clocks, with a manual override to full brightness.
module light_fader
    import lighting_pkg::*;
#(
    parameter int unsigned PWM_BITS = LP_PWM_BITS,
    parameter int unsigned STEP_DIV = LP_STEP_DIV,
    parameter int unsigned STEP     = LP_STEP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                light_on,
    input  logic                manual_override,
    output logic [PWM_BITS-1:0] level,
    output logic                fading,
    output logic                pwm_out
);

    localparam int unsigned LP_MAX  = (1 << PWM_BITS) - 1;
    localparam int unsigned LP_PW   = $clog2(STEP_DIV);

    localparam logic [PWM_BITS:0]   LP_MAX_EXT  = (PWM_BITS+1)'(LP_MAX);
    localparam logic [PWM_BITS:0]   LP_STEP_EXT = (PWM_BITS+1)'(STEP);
    localparam logic [PWM_BITS-1:0] LP_MAX_LVL  = PWM_BITS'(LP_MAX);
    localparam logic [LP_PW-1:0]    LP_TICK     = LP_PW'(STEP_DIV - 1);

    fade_state_t         r_state;
    fade_state_t         w_next_state;
    logic [PWM_BITS-1:0] r_level;
    logic [PWM_BITS-1:0] w_next_level;
    logic [LP_PW-1:0]    r_presc;
    logic [LP_PW-1:0]    w_next_presc;
    logic                r_fading;
    logic                w_next_fading;

    logic                w_tick;
    logic                w_ramping;
    logic [PWM_BITS:0]   w_up_sum;
    logic [PWM_BITS:0]   w_dn_diff;
    logic [PWM_BITS-1:0] w_up_lvl;
    logic [PWM_BITS-1:0] w_dn_lvl;

    assign w_tick    = (r_presc == LP_TICK);
    assign w_ramping = (r_state == FADE_UP) || (r_state == FADE_DOWN);

    // One extra bit: the sum cannot overflow, and the difference's MSB is the borrow.
    assign w_up_sum  = {1'b0, r_level} + LP_STEP_EXT;
    assign w_dn_diff = {1'b0, r_level} - LP_STEP_EXT;
    assign w_up_lvl  = (w_up_sum > LP_MAX_EXT) ? LP_MAX_LVL : w_up_sum[PWM_BITS-1:0];
    assign w_dn_lvl  = w_dn_diff[PWM_BITS] ? '0 : w_dn_diff[PWM_BITS-1:0];

    always_comb begin
        w_next_state = r_state;
        w_next_level = r_level;
        if (manual_override) begin
            w_next_state = BRIGHT;
            w_next_level = LP_MAX_LVL;
        end else begin
            case (r_state)
                DARK: begin
                    w_next_level = '0;
                    if (light_on) w_next_state = FADE_UP;
                end
                FADE_UP: begin
                    if (!light_on) begin
                        w_next_state = FADE_DOWN;
                    end else if (w_tick) begin
                        w_next_level = w_up_lvl;
                        if (w_up_lvl == LP_MAX_LVL) w_next_state = BRIGHT;
                    end
                end
                BRIGHT: begin
                    if (!light_on) w_next_state = FADE_DOWN;
                end
                FADE_DOWN: begin
                    if (light_on) begin
                        w_next_state = FADE_UP;
                    end else if (w_tick) begin
                        w_next_level = w_dn_lvl;
                        if (w_dn_lvl == '0) w_next_state = DARK;
                    end
                end
                default: w_next_state = DARK;
            endcase
        end
    end

    // Prescaler restarts on any state change so a reversal gets a full step period.
    always_comb begin
        w_next_presc = '0;
        if ((w_next_state == r_state) && w_ramping && !w_tick) begin
            w_next_presc = r_presc + LP_PW'(1);
        end
    end

    assign w_next_fading = (w_next_state == FADE_UP) || (w_next_state == FADE_DOWN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= DARK;
            r_level  <= '0;
            r_presc  <= '0;
            r_fading <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_level  <= w_next_level;
            r_presc  <= w_next_presc;
            r_fading <= w_next_fading;
        end
    end

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_gen (
        .clk     (clk),
        .reset   (reset),
        .level   (r_level),
        .pwm_out (pwm_out)
    );

    assign level  = r_level;
    assign fading = r_fading;

endmodule

// File: tb/tb_light_fader.sv
// Self-checking bench for light_fader: directed scenarios plus a randomized
// run, checked against a direction/elapsed-time model of the fade behaviour.
module tb_light_fader;

    localparam int PB      = 8;
    localparam int SD      = 4;
    localparam int ST      = 64;
    localparam int MAXL    = 255;
    localparam int SD_SLOW = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          light_on = 1'b0;
    logic          manual_override = 1'b0;
    logic [PB-1:0] level;
    logic          fading;
    logic          pwm_out;

    logic          s_reset = 1'b1;
    logic          s_light_on = 1'b0;
    logic          s_override = 1'b0;
    logic [PB-1:0] s_level;
    logic          s_fading;
    logic          s_pwm;

    int n_checks = 0;
    int n_errors = 0;

    light_fader #(
        .PWM_BITS (PB),
        .STEP_DIV (SD),
        .STEP     (ST)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .light_on        (light_on),
        .manual_override (manual_override),
        .level           (level),
        .fading          (fading),
        .pwm_out         (pwm_out)
    );

    // Slow-stepping instance so a mid-range level holds long enough to measure duty.
    light_fader #(
        .PWM_BITS (PB),
        .STEP_DIV (SD_SLOW),
        .STEP     (ST)
    ) u_dut_slow (
        .clk             (clk),
        .reset           (s_reset),
        .light_on        (s_light_on),
        .manual_override (s_override),
        .level           (s_level),
        .fading          (s_fading),
        .pwm_out         (s_pwm)
    );

    // Reference model: brightness moves in direction m_dir (+1/-1, 0 = settled),
    // one STEP per SD cycles counted from when that direction was adopted.
    int   m_lvl = 0;
    int   m_dir = 0;
    int   m_since = 0;
    int   m_cnt = 0;
    logic m_pwm = 1'b0;

    task automatic cycle();
        int want;
        @(posedge clk);
        if (reset) begin
            m_lvl = 0; m_dir = 0; m_since = 0; m_cnt = 0; m_pwm = 1'b0;
        end else begin
            m_pwm = (m_cnt < m_lvl);
            m_cnt = (m_cnt + 1) % (MAXL + 1);
            want  = light_on ? 1 : -1;
            if (manual_override) begin
                m_lvl = MAXL; m_dir = 0; m_since = 0;
            end else if (m_dir != want &&
                         !(m_dir == 0 && ((want == 1 && m_lvl == MAXL) || (want == -1 && m_lvl == 0)))) begin
                m_dir = want; m_since = 0;
            end else if (m_dir != 0) begin
                m_since++;
                if (m_since == SD) begin
                    m_since = 0;
                    m_lvl = m_lvl + m_dir * ST;
                    if (m_lvl > MAXL) m_lvl = MAXL;
                    if (m_lvl < 0) m_lvl = 0;
                    if (m_lvl == 0 || m_lvl == MAXL) m_dir = 0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_reset = 1'b1; light_on = 1'b0; manual_override = 1'b0; s_light_on = 1'b0;
        cycle(); cycle();
        n_checks++; if (level !== 8'd0) begin n_errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++; if (fading !== 1'b0) begin n_errors++; $display("FAIL reset_fading: got %0b expected 0", fading); end
        n_checks++; if (pwm_out !== 1'b0) begin n_errors++; $display("FAIL reset_pwm: got %0b expected 0", pwm_out); end
        n_checks++; if (s_level !== 8'd0) begin n_errors++; $display("FAIL reset_slow_level: got %0d expected 0", s_level); end
        reset = 1'b0; s_reset = 1'b0;
    endtask

    task automatic test_fade_up();
        int exp_up[4] = '{64, 128, 192, 255};
        light_on = 1'b1;
        cycle();
        n_checks++; if (fading !== 1'b1) begin n_errors++; $display("FAIL up_start_fading: got %0b expected 1", fading); end
        for (int e = 1; e <= 16; e++) begin
            cycle();
            n_checks++; if (level !== 8'(m_lvl)) begin n_errors++; $display("FAIL up_model_level e%0d: got %0d expected %0d", e, level, m_lvl); end
            n_checks++; if (pwm_out !== m_pwm) begin n_errors++; $display("FAIL up_model_pwm e%0d: got %0b expected %0b", e, pwm_out, m_pwm); end
            if (e % 4 == 0) begin
                n_checks++;
                if (level !== 8'(exp_up[e/4-1])) begin n_errors++; $display("FAIL up_level e%0d: got %0d expected %0d", e, level, exp_up[e/4-1]); end
            end
            if (e < 16) begin
                n_checks++; if (fading !== 1'b1) begin n_errors++; $display("FAIL up_fading e%0d: got %0b expected 1", e, fading); end
            end
        end
        n_checks++; if (fading !== 1'b0) begin n_errors++; $display("FAIL up_bright_fading: got %0b expected 0", fading); end
    endtask

    task automatic test_fade_down();
        int exp_dn[4] = '{191, 127, 63, 0};
        light_on = 1'b0;
        cycle();
        n_checks++; if (fading !== 1'b1 || level !== 8'd255) begin n_errors++; $display("FAIL down_start: level %0d fading %0b expected 255/1", level, fading); end
        for (int e = 1; e <= 16; e++) begin
            cycle();
            n_checks++; if (level !== 8'(m_lvl)) begin n_errors++; $display("FAIL down_model_level e%0d: got %0d expected %0d", e, level, m_lvl); end
            n_checks++; if (pwm_out !== m_pwm) begin n_errors++; $display("FAIL down_model_pwm e%0d: got %0b expected %0b", e, pwm_out, m_pwm); end
            if (e % 4 == 0) begin
                n_checks++;
                if (level !== 8'(exp_dn[e/4-1])) begin n_errors++; $display("FAIL down_level e%0d: got %0d expected %0d", e, level, exp_dn[e/4-1]); end
            end
        end
        n_checks++; if (fading !== 1'b0) begin n_errors++; $display("FAIL down_dark_fading: got %0b expected 0", fading); end
    endtask

    task automatic test_reversal();
        reset = 1'b1; cycle(); reset = 1'b0;
        light_on = 1'b1;
        cycle();
        repeat (8) cycle();
        n_checks++; if (level !== 8'd128) begin n_errors++; $display("FAIL rev_peak: got %0d expected 128", level); end
        light_on = 1'b0;
        cycle();
        n_checks++; if (level !== 8'd128 || fading !== 1'b1) begin n_errors++; $display("FAIL rev_turn: level %0d fading %0b expected 128/1", level, fading); end
        for (int k = 1; k <= 8; k++) begin
            cycle();
            n_checks++; if (level !== 8'(m_lvl)) begin n_errors++; $display("FAIL rev_model_level k%0d: got %0d expected %0d", k, level, m_lvl); end
            if (k == 3) begin
                n_checks++; if (level !== 8'd128) begin n_errors++; $display("FAIL rev_hold: got %0d expected 128", level); end
            end
            if (k == 4) begin
                n_checks++; if (level !== 8'd64) begin n_errors++; $display("FAIL rev_step1: got %0d expected 64", level); end
            end
        end
        n_checks++; if (level !== 8'd0 || fading !== 1'b0) begin n_errors++; $display("FAIL rev_end: level %0d fading %0b expected 0/0", level, fading); end
    endtask

    task automatic test_override();
        int highs;
        manual_override = 1'b1; light_on = 1'b0;
        cycle();
        n_checks++; if (level !== 8'd255 || fading !== 1'b0) begin n_errors++; $display("FAIL ovr_snap: level %0d fading %0b expected 255/0", level, fading); end
        cycle();
        highs = 0;
        for (int k = 0; k < 256; k++) begin
            cycle();
            if (pwm_out === 1'b1) highs++;
        end
        n_checks++; if (highs != 255) begin n_errors++; $display("FAIL ovr_full_duty: got %0d expected 255", highs); end
        n_checks++; if (level !== 8'd255) begin n_errors++; $display("FAIL ovr_held: got %0d expected 255", level); end
        manual_override = 1'b0;
        cycle();
        n_checks++; if (fading !== 1'b1 || level !== 8'd255) begin n_errors++; $display("FAIL ovr_release: level %0d fading %0b expected 255/1", level, fading); end
        repeat (4) cycle();
        n_checks++; if (level !== 8'd191) begin n_errors++; $display("FAIL ovr_first_step: got %0d expected 191", level); end
        repeat (12) cycle();
        n_checks++; if (level !== 8'(m_lvl) || level !== 8'd0) begin n_errors++; $display("FAIL ovr_settle: got %0d expected 0", level); end
    endtask

    task automatic test_pwm_duty();
        int s_highs;
        int m_highs;
        s_light_on = 1'b1;
        cycle();
        repeat (SD_SLOW + 1) cycle();
        n_checks++; if (s_level !== 8'd64) begin n_errors++; $display("FAIL duty_slow_level: got %0d expected 64", s_level); end
        s_highs = 0; m_highs = 0;
        for (int k = 0; k < 256; k++) begin
            cycle();
            if (s_pwm === 1'b1) s_highs++;
            if (pwm_out === 1'b1) m_highs++;
        end
        n_checks++; if (s_highs != 64) begin n_errors++; $display("FAIL duty_64: got %0d expected 64", s_highs); end
        n_checks++; if (m_highs != 0) begin n_errors++; $display("FAIL duty_0: got %0d expected 0", m_highs); end
        s_light_on = 1'b0; s_reset = 1'b1; cycle(); s_reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; cycle(); reset = 1'b0;
        light_on = 1'b1;
        cycle();
        repeat (8) cycle();
        n_checks++; if (level !== 8'd128 || fading !== 1'b1) begin n_errors++; $display("FAIL rmid_pre: level %0d fading %0b expected 128/1", level, fading); end
        reset = 1'b1;
        cycle();
        n_checks++; if (level !== 8'd0 || fading !== 1'b0 || pwm_out !== 1'b0) begin
            n_errors++; $display("FAIL rmid_reset: level %0d fading %0b pwm %0b expected 0/0/0", level, fading, pwm_out);
        end
        reset = 1'b0; light_on = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            n_checks++; if (level !== 8'd0 || fading !== 1'b0) begin n_errors++; $display("FAIL rmid_idle k%0d: level %0d fading %0b expected 0/0", k, level, fading); end
        end
        light_on = 1'b1;
        cycle();
        n_checks++; if (fading !== 1'b1) begin n_errors++; $display("FAIL rmid_restart: got %0b expected 1", fading); end
        repeat (4) cycle();
        n_checks++; if (level !== 8'd64) begin n_errors++; $display("FAIL rmid_step: got %0d expected 64", level); end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                light_on = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 30);
            end
            hold--;
            manual_override = ($urandom_range(0, 24) == 0);
            reset = ($urandom_range(0, 299) == 0);
            cycle();
            n_checks++; if (level !== 8'(m_lvl)) begin n_errors++; $display("FAIL rand_level c%0d: got %0d expected %0d", c, level, m_lvl); end
            n_checks++; if (fading !== (m_dir != 0)) begin n_errors++; $display("FAIL rand_fading c%0d: got %0b expected %0b", c, fading, (m_dir != 0)); end
            n_checks++; if (pwm_out !== m_pwm) begin n_errors++; $display("FAIL rand_pwm c%0d: got %0b expected %0b", c, pwm_out, m_pwm); end
        end
        reset = 1'b0; manual_override = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fade_up();
        test_fade_down();
        test_reversal();
        test_override();
        test_pwm_duty();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
